// File: rtl/rom_program_sequencer.sv
// Fetch/execute controller: walks a ROM program, decodes each instruction and handshakes
// with the ALU, register file and I/O. Optional single-step gating via SEQ_STEP_EN.
module rom_program_sequencer #(
    parameter int unsigned MAX_ADDR    = 255,
    parameter int unsigned ALU_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
`ifdef SEQ_STEP_EN
    input  logic       step,
`endif
    input  logic       start,
    input  logic [1:0] prog_in,
    output logic [1:0] rom_prog,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_instr,
    output logic [3:0] alu_op,
    output logic [1:0] alu_rs1,
    output logic [1:0] alu_rs2,
    output logic       alu_start,
    input  logic       alu_done,
    output logic       rf_wr_en,
    output logic [1:0] rf_wr_sel,
    output logic [1:0] rf_src,
    output logic       in_ready,
    input  logic       in_valid,
    output logic       out_valid,
    output logic [1:0] out_sel,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StExec, StWaitAlu, StWaitIn, StWaitOut, StDone, StHold
    } state_e;

    state_e          state_q, state_d, fetch_st;
    logic [7:0]      pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [1:0]      prog_q, prog_d;
    logic            err_q, err_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            early_q, early_d;
    logic            adv;
    logic [3:0]      op;
    logic            is_alu;

    assign op     = ir_q[7:4];
    assign is_alu = (op[3] == 1'b0) || (op == 4'b1100) || (op == 4'b1101);

`ifdef SEQ_STEP_EN
    assign fetch_st = step ? StFetch : StHold;
`else
    assign fetch_st = StFetch;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
            prog_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            prog_q  <= prog_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            early_q <= early_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        prog_d  = prog_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        early_d = early_q;
        adv     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    prog_d  = prog_in;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = fetch_st;
                end
            end
`ifdef SEQ_STEP_EN
            StHold: begin
                if (step) state_d = StFetch;
            end
`endif
            StFetch: begin
                ir_d    = rom_instr;
                state_d = StExec;
            end
            StExec: begin
                if (is_alu) begin
                    // A done that coincides with the launch pulse must not be lost.
                    early_d = alu_done;
                    tmo_d   = '0;
                    state_d = StWaitAlu;
                end else begin
                    case (op)
                        4'b1001, 4'b1010: state_d = StWaitIn;
                        4'b1011:          state_d = StWaitOut;
                        default:          adv = 1'b1;
                    endcase
                end
            end
            StWaitAlu: begin
                if (alu_done || early_q) begin
                    adv = 1'b1;
                end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitIn: begin
                if (in_valid) adv = 1'b1;
            end
            StWaitOut: begin
                if (out_ready) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (adv) begin
            if (pc_q == 8'(MAX_ADDR)) begin
                err_d   = 1'b1;
                state_d = StDone;
            end else begin
                pc_d    = pc_q + 8'd1;
                state_d = fetch_st;
            end
        end
    end

    always_comb begin
        rom_prog  = prog_q;
        rom_addr  = pc_q;
        alu_op    = op;
        alu_rs1   = ir_q[3:2];
        alu_rs2   = ir_q[1:0];
        rf_wr_sel = ir_q[3:2];
        out_sel   = ir_q[3:2];
        rf_src    = 2'b00;
        alu_start = 1'b0;
        rf_wr_en  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        err       = err_q;
        case (state_q)
            StExec: begin
                alu_start = is_alu;
                rf_wr_en  = (op == 4'b1000);
            end
            StWaitIn: begin
                in_ready = 1'b1;
                rf_wr_en = in_valid;
                rf_src   = (op == 4'b1001) ? 2'b01 : 2'b10;
            end
            StWaitOut: out_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rom_program_sequencer.sv
// Bench for rom_program_sequencer: an instruction-level interpreter expands each program run
// into a per-cycle expected trace plus matching handshake stimulus, checked every cycle.
module tb_rom_program_sequencer;

    localparam int unsigned MAXA = 7;
    localparam int unsigned TMO  = 16;

    logic       clk = 1'b0;
    logic       reset_n, start, alu_done, in_valid, out_ready;
    logic [1:0] prog_in, rom_prog, alu_rs1, alu_rs2, rf_wr_sel, rf_src, out_sel;
    logic [7:0] rom_addr, rom_instr;
    logic [3:0] alu_op;
    logic       alu_start, rf_wr_en, in_ready, out_valid, busy, done, err;

    logic [7:0] rom [4][8];

    always #5 clk = ~clk;
    assign rom_instr = rom[rom_prog][rom_addr[2:0]];

    rom_program_sequencer #(.MAX_ADDR(MAXA), .ALU_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
`ifdef SEQ_STEP_EN
        .step(1'b1),
`endif
        .start(start), .prog_in(prog_in), .rom_prog(rom_prog), .rom_addr(rom_addr),
        .rom_instr(rom_instr), .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_start(alu_start), .alu_done(alu_done), .rf_wr_en(rf_wr_en),
        .rf_wr_sel(rf_wr_sel), .rf_src(rf_src), .in_ready(in_ready), .in_valid(in_valid),
        .out_valid(out_valid), .out_sel(out_sel), .out_ready(out_ready), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        logic       start;
        logic [1:0] prog;
        logic       alu_done, in_valid, out_ready;
    } stim_t;

    typedef struct {
        logic       busy, done, err, alu_start, rf_wr_en, in_ready, out_valid;
        logic [1:0] rom_prog;
        logic [7:0] rom_addr;
        logic [3:0] alu_op;
        logic [1:0] rs1, rs2, wr_sel, src, out_sel;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model state carried between runs.
    int   m_pc = 0;
    int   m_prog = 0;
    logic m_err = 1'b0;

    // Observations gathered during one trace, used for the literal checks.
    int cnt_wr, cnt_alu, last_op, t_start, t_alu, t_pc1, t_done, err_done;
    int ov_len, ov_sel0, ov_unstable, t_ov_last, max_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
        end
    endtask

    function automatic stim_t noise();
        stim_t s;
        s.start     = ($urandom_range(0, 7) == 0);
        s.prog      = 2'($urandom_range(0, 3));
        s.alu_done  = 1'($urandom_range(0, 1));
        s.in_valid  = 1'($urandom_range(0, 1));
        s.out_ready = 1'($urandom_range(0, 1));
        return s;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{default: '0};
        e.err      = m_err;
        e.rom_prog = 2'(m_prog);
        e.rom_addr = 8'(m_pc);
        return e;
    endfunction

    function automatic exp_t busy_exp(input int pc);
        exp_t e;
        e = idle_exp();
        e.busy     = 1'b1;
        e.rom_addr = 8'(pc);
        return e;
    endfunction

    function automatic bit op_is_alu(input logic [3:0] op);
        return (op < 4'd8) || (op == 4'd12) || (op == 4'd13);
    endfunction

    // Interprets program p instruction by instruction. da/di/dout are handshake delays;
    // a negative value draws a fresh random delay for each instruction.
    task automatic build_run(input int p, input int da, input int di, input int dout,
                             input int idle_pre);
        exp_t e;
        stim_t s;
        int pc, d, w;
        logic [7:0] ins;
        logic [3:0] op;
        bit fin, step_on;
        for (int k = 0; k < idle_pre; k++) begin
            e = idle_exp(); s = noise(); s.start = 1'b0;
            sq.push_back(s); eq.push_back(e);
        end
        e = idle_exp(); s = noise(); s.start = 1'b1; s.prog = 2'(p);
        sq.push_back(s); eq.push_back(e);
        m_prog = p; m_err = 1'b0; pc = 0; fin = 1'b0;
        while (!fin) begin
            ins = rom[p][pc];
            op  = ins[7:4];
            step_on = 1'b0;
            e = busy_exp(pc); s = noise();
            sq.push_back(s); eq.push_back(e);
            e = busy_exp(pc); s = noise(); s.alu_done = 1'b0;
            if (op_is_alu(op)) begin
                e.alu_start = 1'b1; e.alu_op = op; e.rs1 = ins[3:2]; e.rs2 = ins[1:0];
                d = (da < 0) ? int'($urandom_range(0, 20)) : da;
                s.alu_done = (d == 0);
                sq.push_back(s); eq.push_back(e);
                if (d > int'(TMO)) begin
                    for (int j = 1; j <= int'(TMO); j++) begin
                        e = busy_exp(pc); s = noise(); s.alu_done = 1'b0;
                        sq.push_back(s); eq.push_back(e);
                    end
                    m_err = 1'b1; fin = 1'b1;
                end else begin
                    for (int j = 1; j <= ((d == 0) ? 1 : d); j++) begin
                        e = busy_exp(pc); s = noise();
                        if (d != 0) s.alu_done = (j == d);
                        sq.push_back(s); eq.push_back(e);
                    end
                    step_on = 1'b1;
                end
            end else if (op == 4'd8) begin
                e.rf_wr_en = 1'b1; e.wr_sel = ins[3:2]; e.src = 2'b00;
                sq.push_back(s); eq.push_back(e);
                step_on = 1'b1;
            end else if (op == 4'd9 || op == 4'd10) begin
                sq.push_back(s); eq.push_back(e);
                w = (di < 0) ? int'($urandom_range(0, 5)) : di;
                for (int j = 0; j <= w; j++) begin
                    e = busy_exp(pc); s = noise();
                    e.in_ready = 1'b1;
                    s.in_valid = (j == w);
                    if (j == w) begin
                        e.rf_wr_en = 1'b1; e.wr_sel = ins[3:2];
                        e.src = (op == 4'd9) ? 2'b01 : 2'b10;
                    end
                    sq.push_back(s); eq.push_back(e);
                end
                step_on = 1'b1;
            end else if (op == 4'd11) begin
                sq.push_back(s); eq.push_back(e);
                w = (dout < 0) ? int'($urandom_range(0, 5)) : dout;
                for (int j = 0; j <= w; j++) begin
                    e = busy_exp(pc); s = noise();
                    e.out_valid = 1'b1; e.out_sel = ins[3:2];
                    s.out_ready = (j == w);
                    sq.push_back(s); eq.push_back(e);
                end
                fin = 1'b1;
            end else begin
                sq.push_back(s); eq.push_back(e);
                step_on = 1'b1;
            end
            if (step_on) begin
                if (pc == int'(MAXA)) begin
                    m_err = 1'b1; fin = 1'b1;
                end else begin
                    pc++;
                end
            end
        end
        e = busy_exp(pc); e.done = 1'b1; s = noise();
        sq.push_back(s); eq.push_back(e);
        m_pc = pc;
    endtask

    task automatic run_trace();
        stim_t s;
        exp_t e;
        cnt_wr = 0; cnt_alu = 0; last_op = -1; t_start = -1; t_alu = -1; t_pc1 = -1;
        t_done = -1; err_done = -1; ov_len = 0; ov_sel0 = -1; ov_unstable = 0;
        t_ov_last = -1; max_addr = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            @(posedge clk); #1;
            start = s.start; prog_in = s.prog; alu_done = s.alu_done;
            in_valid = s.in_valid; out_ready = s.out_ready;
            @(negedge clk);
            cyc++;
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("err", 32'(err), 32'(e.err));
            chk("alu_start", 32'(alu_start), 32'(e.alu_start));
            chk("rf_wr_en", 32'(rf_wr_en), 32'(e.rf_wr_en));
            chk("in_ready", 32'(in_ready), 32'(e.in_ready));
            chk("out_valid", 32'(out_valid), 32'(e.out_valid));
            chk("rom_addr", 32'(rom_addr), 32'(e.rom_addr));
            chk("rom_prog", 32'(rom_prog), 32'(e.rom_prog));
            if (e.alu_start) begin
                chk("alu_op", 32'(alu_op), 32'(e.alu_op));
                chk("alu_rs1", 32'(alu_rs1), 32'(e.rs1));
                chk("alu_rs2", 32'(alu_rs2), 32'(e.rs2));
            end
            if (e.rf_wr_en) begin
                chk("rf_wr_sel", 32'(rf_wr_sel), 32'(e.wr_sel));
                chk("rf_src", 32'(rf_src), 32'(e.src));
            end
            if (e.out_valid) chk("out_sel", 32'(out_sel), 32'(e.out_sel));
            if (s.start && !e.busy) t_start = cyc;
            if (rf_wr_en) cnt_wr++;
            if (alu_start) begin cnt_alu++; last_op = int'(alu_op); t_alu = cyc; end
            if (busy && rom_addr == 8'd1 && t_pc1 < 0) t_pc1 = cyc;
            if (busy && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (out_valid) begin
                ov_len++;
                if (ov_len == 1) ov_sel0 = int'(out_sel);
                else if (int'(out_sel) != ov_sel0) ov_unstable = 1;
                t_ov_last = cyc;
            end
            if (done) begin t_done = cyc; err_done = int'(err); end
        end
        @(posedge clk); #1;
        start = 1'b0; alu_done = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0; start = 1'b0; prog_in = 2'b00;
        alu_done = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 8; a++) rom[p][a] = 8'hE0;
        // prog0: LDA r0, LDB r1, MUL r0 r1, PUSH r0, OUT r0
        rom[0][0] = 8'h90; rom[0][1] = 8'hA4; rom[0][2] = 8'h21;
        rom[0][3] = 8'h80; rom[0][4] = 8'hB0;
        // prog1: ADD r1 r2, OUT r1; prog2: OUT r2; prog3: NOPs only
        rom[1][0] = 8'h06; rom[1][1] = 8'hB4;
        rom[2][0] = 8'hB8;
        for (int a = 0; a < 8; a++) rom[3][a] = (a % 2 == 0) ? 8'hE0 : 8'hF3;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_addr", 32'(rom_addr), 32'd0);
        chk("reset_prog", 32'(rom_prog), 32'd0);
        chk("reset_strobes", 32'({alu_start, rf_wr_en, in_ready, out_valid}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        build_run(0, 0, 0, 0, 1);
        run_trace();
        chk("prog0_wr_pulses", 32'(cnt_wr), 32'd3);
        chk("prog0_alu_count", 32'(cnt_alu), 32'd1);
        chk("prog0_alu_op", 32'(last_op), 32'd2);
        chk("prog0_out_sel", 32'(ov_sel0), 32'd0);
        chk("prog0_done_latency", 32'(t_done - t_start), 32'd15);
        chk("prog0_err", 32'(err_done), 32'd0);

        build_run(1, 5, 0, 0, 2);
        run_trace();
        chk("alu5_start_pulses", 32'(cnt_alu), 32'd1);
        chk("alu5_pc_advance", 32'(t_pc1 - t_alu), 32'd6);

        build_run(1, 99, 0, 0, 1);
        run_trace();
        chk("tmo_done_latency", 32'(t_done - t_alu), 32'd17);
        chk("tmo_err", 32'(err_done), 32'd1);
        chk("tmo_no_advance", 32'(t_pc1 < 0), 32'd1);

        build_run(2, 0, 0, 4, 1);
        run_trace();
        chk("out_hold_len", 32'(ov_len), 32'd5);
        chk("out_sel_value", 32'(ov_sel0), 32'd2);
        chk("out_sel_stable", 32'(ov_unstable), 32'd0);
        chk("out_done_next", 32'(t_done - t_ov_last), 32'd1);

        build_run(3, 0, 0, 0, 1);
        run_trace();
        chk("nop_max_pc", 32'(max_addr), 32'(MAXA));
        chk("nop_err", 32'(err_done), 32'd1);
        chk("nop_latency", 32'(t_done - t_start), 32'd17);

        for (int r = 0; r < 40; r++) begin
            int p;
            p = int'($urandom_range(0, 3));
            for (int a = 0; a < 8; a++) rom[p][a] = 8'($urandom);
            build_run(p, -1, -1, -1, int'($urandom_range(0, 3)));
            run_trace();
        end

        // Abort in WAIT_IN: restore an LDA-first program and reset while waiting.
        rom[0][0] = 8'h90;
        @(posedge clk); #1;
        start = 1'b1; prog_in = 2'b00; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        chk("rst_reached_wait_in", 32'(seen), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
